// File: rtl/food_multi.sv
// Multi-slot food manager for the VGA snake game: LFSR placement, eat/expiry
// bookkeeping and a 2-stage per-pixel "food here" pipeline.
module food_multi #(
    parameter int unsigned N_FOOD      = 4,
    parameter int unsigned FOOD_SIZE   = 10,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned LIFE_FRAMES = 600,
    parameter logic [15:0] SEED        = 16'hACE1,
    localparam int unsigned IDW        = (N_FOOD > 1) ? $clog2(N_FOOD) : 1
) (
    input  logic           VGA_clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           update,
    input  logic [9:0]     xCount,
    input  logic [9:0]     yCount,
    input  logic [9:0]     head_x,
    input  logic [9:0]     head_y,
    output logic           apple,
    output logic [IDW-1:0] apple_id,
    output logic           eaten,
    output logic [IDW-1:0] eaten_id,
    output logic           expired,
    output logic [3:0]     food_count
);

    localparam int unsigned CW        = (LIFE_FRAMES > 0) ? $clog2(LIFE_FRAMES + 1) : 1;
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] POLY      = 16'hB400;
    localparam logic [10:0] FS        = 11'(FOOD_SIZE);
    localparam logic [10:0] X_MAX     = 11'(H_ACTIVE - FOOD_SIZE);
    localparam logic [10:0] Y_MAX     = 11'(V_ACTIVE - FOOD_SIZE);
    localparam logic [CW-1:0] LIFE_LAST = CW'(LIFE_FRAMES - 1);
    localparam bit          EXPIRE_EN = (LIFE_FRAMES != 0);

    logic [15:0]       lfsr;
    logic [9:0]        fx   [N_FOOD];
    logic [9:0]        fy   [N_FOOD];
    logic [CW-1:0]     life [N_FOOD];
    logic [N_FOOD-1:0] valid;
    logic [N_FOOD-1:0] inBox;

    logic [9:0]        candX;
    logic [9:0]        candY;
    logic              candOk;
    logic [N_FOOD-1:0] fillMask;
    logic [N_FOOD-1:0] eatMask;
    logic [N_FOOD-1:0] expMask;
    logic [N_FOOD-1:0] pixHit;
    logic [IDW-1:0]    eatIdx;
    logic [IDW-1:0]    pixIdx;
    logic [3:0]        validCount;
    logic              fillFound;
    logic              eatFound;
    logic              pixFound;

    // 11-bit compares so box edges near 1023 cannot wrap
    function automatic logic boxOverlap(input logic [9:0] ax, input logic [9:0] ay,
                                        input logic [9:0] bx, input logic [9:0] by);
        return (11'(ax) < 11'(bx) + FS) && (11'(bx) < 11'(ax) + FS) &&
               (11'(ay) < 11'(by) + FS) && (11'(by) < 11'(ay) + FS);
    endfunction

    // Slot selection: refill target, eat target, expiry set, pixel hits and priority
    always_comb begin
        candX      = lfsr[9:0];
        candY      = {1'b0, lfsr[15:7]};
        candOk     = (11'(candX) <= X_MAX) && (11'(candY) <= Y_MAX) &&
                     !boxOverlap(candX, candY, head_x, head_y);
        fillMask   = '0;
        eatMask    = '0;
        expMask    = '0;
        pixHit     = '0;
        eatIdx     = '0;
        pixIdx     = '0;
        validCount = '0;
        fillFound  = 1'b0;
        eatFound   = 1'b0;
        pixFound   = 1'b0;
        for (int i = 0; i < int'(N_FOOD); i++) begin
            if (!valid[i] && !fillFound) begin
                fillMask[i] = candOk;
                fillFound   = 1'b1;
            end
            if (update && valid[i] && !eatFound && boxOverlap(fx[i], fy[i], head_x, head_y)) begin
                eatMask[i] = 1'b1;
                eatIdx     = IDW'(i);
                eatFound   = 1'b1;
            end
            expMask[i] = EXPIRE_EN && update && valid[i] && !eatMask[i] && (life[i] == LIFE_LAST);
            pixHit[i]  = start && valid[i] &&
                         (11'(fx[i]) <= 11'(xCount)) && (11'(xCount) < 11'(fx[i]) + FS) &&
                         (11'(fy[i]) <= 11'(yCount)) && (11'(yCount) < 11'(fy[i]) + FS);
            if (inBox[i] && !pixFound) begin
                pixIdx   = IDW'(i);
                pixFound = 1'b1;
            end
            validCount = validCount + 4'(valid[i]);
        end
    end

    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= LFSR_INIT;
            valid      <= '0;
            inBox      <= '0;
            apple      <= 1'b0;
            apple_id   <= '0;
            eaten      <= 1'b0;
            eaten_id   <= '0;
            expired    <= 1'b0;
            food_count <= '0;
            for (int i = 0; i < int'(N_FOOD); i++) begin
                fx[i]   <= '0;
                fy[i]   <= '0;
                life[i] <= '0;
            end
        end else begin
            lfsr       <= lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);
            inBox      <= pixHit;
            apple      <= start && (|inBox);
            apple_id   <= start ? pixIdx : '0;
            food_count <= validCount;
            if (!start) begin
                valid   <= '0;
                eaten   <= 1'b0;
                expired <= 1'b0;
                for (int i = 0; i < int'(N_FOOD); i++) begin
                    life[i] <= '0;
                end
            end else begin
                eaten   <= |eatMask;
                expired <= |expMask;
                if (|eatMask) begin
                    eaten_id <= eatIdx;
                end
                // A slot is either being filled, being retired, or aging
                for (int i = 0; i < int'(N_FOOD); i++) begin
                    if (fillMask[i]) begin
                        fx[i]    <= candX;
                        fy[i]    <= candY;
                        valid[i] <= 1'b1;
                        life[i]  <= '0;
                    end else if (eatMask[i] || expMask[i]) begin
                        valid[i] <= 1'b0;
                        life[i]  <= '0;
                    end else if (EXPIRE_EN && update && valid[i]) begin
                        life[i] <= life[i] + CW'(1);
                    end
                end
            end
        end
    end

endmodule
